// File: rtl/xc_malu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xc_malu_pkg
//  Description : Shared constants and types for the MALU decode front-end
//                and the two-port MALU arbiter/sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package xc_malu_pkg;

  localparam int XLEN  = 32;
  localparam int UOP_W = 14;
  localparam int PW_W  = 5;
  localparam int ST_W  = 4;

  // uop one-hot bit indices, LSB first
  localparam int UOP_DIV    = 0;
  localparam int UOP_DIVU   = 1;
  localparam int UOP_REM    = 2;
  localparam int UOP_REMU   = 3;
  localparam int UOP_MUL    = 4;
  localparam int UOP_MULU   = 5;
  localparam int UOP_MULSU  = 6;
  localparam int UOP_CLMUL  = 7;
  localparam int UOP_PMUL   = 8;
  localparam int UOP_PCLMUL = 9;
  localparam int UOP_MADD   = 10;
  localparam int UOP_MSUB   = 11;
  localparam int UOP_MACC   = 12;
  localparam int UOP_MMUL   = 13;

  // pack-width one-hot bit indices, LSB first
  localparam int PW_32 = 0;
  localparam int PW_16 = 1;
  localparam int PW_8  = 2;
  localparam int PW_4  = 3;
  localparam int PW_2  = 4;

  // sequencer states, one-hot
  localparam logic [ST_W-1:0] ST_IDLE  = 4'b0001;
  localparam logic [ST_W-1:0] ST_ISSUE = 4'b0010;
  localparam logic [ST_W-1:0] ST_RESP  = 4'b0100;
  localparam logic [ST_W-1:0] ST_FLUSH = 4'b1000;

  // one latched MALU operation
  typedef struct packed {
    logic [UOP_W-1:0] uop;
    logic [PW_W-1:0]  pw;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [XLEN-1:0]  rs3;
  } malu_op_t;

  // true when exactly one uop bit is set
  function automatic logic uop_onehot(input logic [UOP_W-1:0] v);
    return (v != '0) && ((v & (v - UOP_W'(1))) == '0);
  endfunction

  // true when exactly one pack-width bit is set
  function automatic logic pw_onehot(input logic [PW_W-1:0] v);
    return (v != '0) && ((v & (v - PW_W'(1))) == '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/xc_malu_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : xc_malu_arb_if
//  Description : Requester-side bus of the MALU arbiter: two request ports
//                with operands and kill, two response handshakes sharing one
//                result/error pair.
//  Revision    : 1.0 - initial release
// ============================================================================
interface xc_malu_arb_if;
  import xc_malu_pkg::*;

  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0][UOP_W-1:0]  req_uop;
  logic [1:0][PW_W-1:0]   req_pw;
  logic [1:0][XLEN-1:0]   req_rs1;
  logic [1:0][XLEN-1:0]   req_rs2;
  logic [1:0][XLEN-1:0]   req_rs3;
  logic [1:0]             req_kill;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [63:0]            rsp_result;
  logic                   rsp_err;

  // requesters
  modport master (
    output req_valid, req_uop, req_pw, req_rs1, req_rs2, req_rs3, req_kill,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  // arbiter
  modport slave (
    input  req_valid, req_uop, req_pw, req_rs1, req_rs2, req_rs3, req_kill,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface
`default_nettype wire

// File: rtl/xc_malu_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : xc_malu_rr_arb2
//  Description : Two-input round-robin arbiter. A lone requester always wins;
//                on contention the port not granted last wins. The pointer
//                only moves when the grant is actually consumed.
//  Revision    : 1.0 - initial release
// ============================================================================
module xc_malu_rr_arb2 (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o,
  output logic       gid_o
);

  // port granted most recently; resets to 1 so port 0 wins first contention
  logic last_q;

  // pick the winner from the current requests and the pointer
  always_comb begin
    gid_o   = 1'b0;
    grant_o = 2'b00;
    if (req_i == 2'b11) begin
      gid_o = ~last_q;
    end else begin
      gid_o = req_i[1];
    end
    if (req_i != 2'b00) begin
      grant_o = gid_o ? 2'b10 : 2'b01;
    end
  end

  // move the pointer to the winner once its request is accepted
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_q <= 1'b1;
    end else if (advance_i) begin
      last_q <= gid_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/xc_malu_arb.sv
`default_nettype none
// ============================================================================
//  Module      : xc_malu_arb
//  Description : Shares one MALU between two requesters. Accepts one
//                operation at a time, drives the MALU valid/flush protocol,
//                returns the 64-bit result on the owner's response port and
//                scrubs MALU state with random data after every operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module xc_malu_arb
  import xc_malu_pkg::*;
#(
  parameter int TIMEOUT   = 64,
  parameter int FLUSH_CYC = 1
) (
  input  logic            clock,
  input  logic            resetn,
  xc_malu_arb_if.slave    req_if,
  input  logic [31:0]     rng_data_i,
  output logic            malu_valid_o,
  output logic            malu_flush_o,
  output logic [31:0]     malu_flush_data_o,
  output logic [UOP_W-1:0] malu_uop_o,
  output logic [PW_W-1:0] malu_pw_o,
  output logic [XLEN-1:0] malu_rs1_o,
  output logic [XLEN-1:0] malu_rs2_o,
  output logic [XLEN-1:0] malu_rs3_o,
  input  logic [63:0]     malu_result_i,
  input  logic            malu_ready_i
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYC + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYC - 1);

  logic [ST_W-1:0]   state_q, state_d;
  logic              owner_q, owner_d;
  malu_op_t          op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic [63:0]       result_q, result_d;
  logic              err_q, err_d;
  // set only when the current operation really reached the MALU
  logic              issued_q, issued_d;

  logic [1:0] w_grant;
  logic       w_gid;
  logic       w_accept;
  malu_op_t   w_req_op;
  logic       w_req_legal;
  logic       w_kill;
  logic       w_rsp_hs;
  logic       w_in_issue;

  xc_malu_rr_arb2 u_rr_arb (
    .clock     (clock),
    .resetn    (resetn),
    .req_i     (req_if.req_valid),
    .advance_i (w_accept),
    .grant_o   (w_grant),
    .gid_o     (w_gid)
  );

  assign w_accept   = (state_q == ST_IDLE) && (req_if.req_valid != 2'b00);
  assign w_in_issue = (state_q == ST_ISSUE);

  assign w_req_op = '{
    uop: req_if.req_uop[w_gid],
    pw : req_if.req_pw[w_gid],
    rs1: req_if.req_rs1[w_gid],
    rs2: req_if.req_rs2[w_gid],
    rs3: req_if.req_rs3[w_gid]
  };
  assign w_req_legal = uop_onehot(w_req_op.uop) && pw_onehot(w_req_op.pw);

  // only the owner may kill its operation or complete its response
  assign w_kill   = req_if.req_kill[owner_q];
  assign w_rsp_hs = req_if.rsp_ready[owner_q];

  // requester-facing outputs
  assign req_if.req_ready  = (state_q == ST_IDLE) ? w_grant : 2'b00;
  assign req_if.rsp_valid  = (state_q == ST_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign req_if.rsp_result = result_q;
  assign req_if.rsp_err    = err_q;

  // MALU-facing outputs; operands are visible only while issuing, and valid
  // stays up through RESP so the MALU holds its DONE state
  assign malu_valid_o      = w_in_issue || ((state_q == ST_RESP) && issued_q);
  assign malu_uop_o        = w_in_issue ? op_q.uop : '0;
  assign malu_pw_o         = w_in_issue ? op_q.pw  : '0;
  assign malu_rs1_o        = w_in_issue ? op_q.rs1 : '0;
  assign malu_rs2_o        = w_in_issue ? op_q.rs2 : '0;
  assign malu_rs3_o        = w_in_issue ? op_q.rs3 : '0;
  assign malu_flush_o      = (state_q == ST_FLUSH);
  assign malu_flush_data_o = (state_q == ST_FLUSH) ? rng_data_i : '0;

  // sequencer next-state: accept, issue/timeout, respond, scrub
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    fcnt_d   = fcnt_q;
    result_d = result_q;
    err_d    = err_q;
    issued_d = issued_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          op_d    = w_req_op;
          owner_d = w_gid;
          cnt_d   = '0;
          if (w_req_legal) begin
            issued_d = 1'b1;
            state_d  = ST_ISSUE;
          end else begin
            // bad encoding is answered directly without touching the MALU
            issued_d = 1'b0;
            result_d = '0;
            err_d    = 1'b1;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (w_kill) begin
          result_d = '0;
          err_d    = 1'b0;
          fcnt_d   = '0;
          state_d  = ST_FLUSH;
        end else if (malu_ready_i) begin
          result_d = malu_result_i;
          err_d    = 1'b0;
          state_d  = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (w_kill || w_rsp_hs) begin
          // drop the result so operand-derived data does not linger
          result_d = '0;
          err_d    = 1'b0;
          fcnt_d   = '0;
          state_d  = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == FCNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q + FCNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      op_q     <= '0;
      cnt_q    <= '0;
      fcnt_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      issued_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      fcnt_q   <= fcnt_d;
      result_q <= result_d;
      err_q    <= err_d;
      issued_q <= issued_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xc_malu_arb
//  Description : Self-checking bench for xc_malu_arb with a behavioural MALU
//                stub and a reference model of expected responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xc_malu_arb;
  import xc_malu_pkg::*;

  logic clock = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  xc_malu_arb_if bus ();

  logic [31:0] rng_data;
  logic        malu_valid, malu_flush, malu_ready;
  logic [31:0] malu_flush_data, malu_rs1, malu_rs2, malu_rs3;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic [63:0] malu_result;

  xc_malu_arb #(.TIMEOUT(64), .FLUSH_CYC(1)) dut (
    .clock             (clock),
    .resetn            (resetn),
    .req_if            (bus),
    .rng_data_i        (rng_data),
    .malu_valid_o      (malu_valid),
    .malu_flush_o      (malu_flush),
    .malu_flush_data_o (malu_flush_data),
    .malu_uop_o        (malu_uop),
    .malu_pw_o         (malu_pw),
    .malu_rs1_o        (malu_rs1),
    .malu_rs2_o        (malu_rs2),
    .malu_rs3_o        (malu_rs3),
    .malu_result_i     (malu_result),
    .malu_ready_i      (malu_ready)
  );

  int checks = 0;
  int errors = 0;
  int lg     = 1;   // port granted last, per the round-robin rule
  int stub_lat   = 0;
  bit stub_never = 1'b0;
  int scnt;
  logic sdone;

  // Behavioural MALU arithmetic used for both the stub and expectations
  function automatic logic [63:0] ref_malu(input logic [13:0] u,
                                           input logic [31:0] a, b, c);
    if (u[UOP_MUL] || u[UOP_MULU]) return 64'(a) * 64'(b);
    if (u[UOP_DIVU]) return (b == 32'd0) ? {a, 32'hffff_ffff} : {a % b, a / b};
    return {a ^ c, b + c};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // MALU stub: ready pulses stub_lat+1 cycles after valid is first seen
  always @(posedge clock) begin
    if (!resetn || !malu_valid) begin
      scnt <= 0; sdone <= 1'b0; malu_ready <= 1'b0;
    end else if (sdone) begin
      malu_ready <= 1'b0;
    end else if (!stub_never && scnt == stub_lat) begin
      malu_ready  <= 1'b1;
      malu_result <= ref_malu(malu_uop, malu_rs1, malu_rs2, malu_rs3);
      sdone       <= 1'b1;
    end else begin
      scnt <= scnt + 1;
    end
  end

  // Mutual exclusion of the per-port handshakes, every cycle
  always @(negedge clock) begin
    if (resetn) begin
      chk("rsp_valid_excl", 64'($countones(bus.rsp_valid) <= 1), 64'd1);
      chk("req_ready_excl", 64'($countones(bus.req_ready) <= 1), 64'd1);
    end
  end

  function automatic logic [1:0] oh(input int p);
    return (p != 0) ? 2'b10 : 2'b01;
  endfunction

  task automatic drive_req(input int p, input logic [13:0] u, input logic [4:0] w,
                           input logic [31:0] a, b, c);
    bus.req_valid[p] = 1'b1; bus.req_uop[p] = u; bus.req_pw[p] = w;
    bus.req_rs1[p] = a; bus.req_rs2[p] = b; bus.req_rs3[p] = c;
  endtask

  // One full operation: accept, wait for response, optional hold, flush
  task automatic do_op(input int p, input logic [13:0] u, input logic [4:0] w,
                       input logic [31:0] a, b, c, input int lat, input int hold,
                       input bit never);
    bit legal, seen_v, got;
    logic [63:0] er;
    logic ee;
    int explat, i;
    legal = ($countones(u) == 1) && ($countones(w) == 1);
    if (!legal)     begin er = '0; ee = 1'b1; explat = 0;  end
    else if (never) begin er = '0; ee = 1'b1; explat = 64; end
    else            begin er = ref_malu(u, a, b, c); ee = 1'b0; explat = lat + 2; end
    stub_lat = lat; stub_never = never;
    drive_req(p, u, w, a, b, c);
    #1;
    chk("accept_ready", 64'(bus.req_ready), 64'(oh(p)));
    @(posedge clock); lg = p;
    @(negedge clock); bus.req_valid[p] = 1'b0;
    i = 0; seen_v = 1'b0; got = 1'b0;
    while (i < 200) begin
      if (bus.rsp_valid != 2'b00) begin got = 1'b1; break; end
      if (malu_valid) begin
        seen_v = 1'b1;
        chk("issue_uop_pw", 64'({malu_uop, malu_pw}), 64'({u, w}));
        chk("issue_rs12", {malu_rs1, malu_rs2}, {a, b});
        chk("issue_rs3", 64'(malu_rs3), 64'(c));
      end
      @(negedge clock); i++;
    end
    chk("rsp_seen", 64'(got), 64'd1);
    if (!got) return;
    chk("rsp_latency", 64'(i), 64'(explat));
    chk("rsp_port", 64'(bus.rsp_valid), 64'(oh(p)));
    chk("rsp_result", bus.rsp_result, er);
    chk("rsp_err", 64'(bus.rsp_err), 64'(ee));
    chk("malu_touched", 64'(seen_v), 64'(legal));
    chk("resp_malu_valid", 64'(malu_valid), 64'(legal));
    if (hold > 0) drive_req(1 - p, 14'(1) << UOP_MUL, 5'b1, 32'd3, 32'd5, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      chk("hold_result", bus.rsp_result, er);
      chk("hold_err", 64'(bus.rsp_err), 64'(ee));
      chk("hold_valid", 64'({bus.rsp_valid, malu_valid}), 64'({oh(p), legal}));
      chk("hold_no_accept", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid[1 - p] = 1'b0;
    rng_data = $urandom;
    bus.rsp_ready[p] = 1'b1;
    @(negedge clock);
    bus.rsp_ready[p] = 1'b0;
    chk("flush_on", 64'(malu_flush), 64'd1);
    chk("flush_data", 64'(malu_flush_data), 64'(rng_data));
    chk("flush_state", 64'({malu_valid, bus.rsp_valid}), 64'd0);
    chk("flush_result_clr", bus.rsp_result, 64'd0);
    @(negedge clock);
    chk("flush_len", 64'(malu_flush), 64'd0);
  endtask

  // Operation killed by its owner at wait index kill_at
  task automatic kill_op(input int p, input logic [13:0] u, input logic [31:0] a, b,
                         input int lat, input int kill_at);
    bit saw;
    stub_lat = lat; stub_never = 1'b0;
    drive_req(p, u, 5'b1, a, b, 32'd1);
    #1;
    chk("kill_accept", 64'(bus.req_ready), 64'(oh(p)));
    @(posedge clock); lg = p;
    @(negedge clock); bus.req_valid[p] = 1'b0;
    for (int i = 0; i < kill_at; i++) @(negedge clock);
    if (kill_at == lat + 1) chk("kill_with_ready", 64'(malu_ready), 64'd1);
    bus.req_kill[p] = 1'b1;
    @(negedge clock);
    bus.req_kill[p] = 1'b0;
    chk("kill_flush", 64'(malu_flush), 64'd1);
    chk("kill_no_rsp", 64'({bus.rsp_valid, malu_valid}), 64'd0);
    saw = 1'b0;
    @(negedge clock);
    chk("kill_flush_len", 64'(malu_flush), 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid != 2'b00) saw = 1'b1;
      @(negedge clock);
    end
    chk("kill_never_rsp", 64'(saw), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [13:0] u;
    logic [4:0]  w;
    int q[$];
    int nresp, ngrant, o, p, r;
    logic [31:0] da [2];
    logic [31:0] db [2];

    bus.req_valid = '0; bus.req_uop = '0; bus.req_pw = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rs3 = '0;
    bus.req_kill = '0; bus.rsp_ready = '0; rng_data = '0;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_valids", 64'({bus.rsp_valid, malu_valid, malu_flush}), 64'd0);
    chk("rst_err_result", {bus.rsp_result[62:0], bus.rsp_err}, 64'd0);
    chk("rst_malu_ops", 64'({malu_uop, malu_pw, malu_rs1}), 64'd0);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_no_ready", 64'(bus.req_ready), 64'd0);

    // contention from reset: grants alternate 0,1,0,1
    da[0] = 32'd100; db[0] = 32'd7; da[1] = 32'd9; db[1] = 32'd3;
    stub_lat = 2; stub_never = 1'b0;
    drive_req(0, 14'(1) << UOP_DIVU, 5'b1, da[0], db[0], 32'd0);
    drive_req(1, 14'(1) << UOP_DIVU, 5'b1, da[1], db[1], 32'd0);
    bus.rsp_ready = 2'b11;
    #1;
    nresp = 0; ngrant = 0;
    for (int cyc = 0; cyc < 300 && nresp < 4; cyc++) begin
      if (bus.req_ready != 2'b00) begin
        chk("dual_grant_rr", 64'(bus.req_ready), 64'(oh(1 - lg)));
        chk("dual_grant_seq", 64'(bus.req_ready[1]), 64'(ngrant % 2));
        q.push_back(int'(bus.req_ready[1]));
        lg = int'(bus.req_ready[1]);
        ngrant++;
      end
      if (bus.rsp_valid != 2'b00) begin
        o = (q.size() > 0) ? q.pop_front() : 0;
        chk("dual_rsp_port", 64'(bus.rsp_valid), 64'(oh(o)));
        chk("dual_rsp_result", bus.rsp_result,
            ref_malu(14'(1) << UOP_DIVU, da[o], db[o], 32'd0));
        chk("dual_rsp_err", 64'(bus.rsp_err), 64'd0);
        nresp++;
        if (nresp == 4) bus.req_valid = 2'b00;
      end
      @(negedge clock);
    end
    chk("dual_done", 64'(nresp), 64'd4);
    chk("dual_known_results", ref_malu(14'(1) << UOP_DIVU, 32'd100, 32'd7, 32'd0),
        {32'd2, 32'd14});
    repeat (2) @(negedge clock);
    bus.rsp_ready = 2'b00;

    // directed: mul 7*6, illegal uop, timeout, kills, held response
    do_op(0, 14'(1) << UOP_MUL, 5'b1 << PW_32, 32'd7, 32'd6, 32'd0, 3, 0, 1'b0);
    do_op(1, 14'b11, 5'b1, 32'd5, 32'd5, 32'd5, 0, 0, 1'b0);
    do_op(0, 14'(1) << UOP_MMUL, 5'b1, 32'd1, 32'd2, 32'd3, 0, 0, 1'b1);
    kill_op(0, 14'(1) << UOP_MMUL, 32'h1234, 32'h55, 20, 5);
    do_op(1, 14'(1) << UOP_MULU, 5'b1, 32'hffff_ffff, 32'd2, 32'd0, 1, 0, 1'b0);
    kill_op(1, 14'(1) << UOP_MUL, 32'd11, 32'd13, 4, 5);
    do_op(0, 14'(1) << UOP_MACC, 5'b1 << PW_8, 32'hdead, 32'hbeef, 32'h77, 2, 10, 1'b0);

    // reset mid-operation: no response, pointer back to port-0 preference
    stub_lat = 30; stub_never = 1'b0;
    drive_req(1, 14'(1) << UOP_MUL, 5'b1, 32'd4, 32'd4, 32'd0);
    @(negedge clock); bus.req_valid = 2'b00;
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1; lg = 1;
    @(negedge clock);
    chk("midrst_quiet", 64'({bus.rsp_valid, malu_valid, malu_flush}), 64'd0);

    // randomized operations with non-owner kill noise
    for (int n = 0; n < 24; n++) begin
      p = int'($urandom_range(0, 1));
      u = 14'(1) << $urandom_range(0, 13);
      w = 5'(1) << $urandom_range(0, 4);
      r = int'($urandom_range(0, 5));
      if (r == 0) u = u | (14'(1) << ((n + 3) % 14)) | (14'(1) << ((n + 4) % 14));
      if (r == 1) w = 5'b0;
      bus.req_kill[1 - p] = 1'($urandom_range(0, 1));
      do_op(p, u, w, $urandom, $urandom, $urandom, int'($urandom_range(0, 6)),
            int'($urandom_range(0, 3)), 1'b0);
      bus.req_kill = 2'b00;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
